hb_monitor: RTL

- Consumes the free-running heartbeat square wave and turns it into a board status LED with a heartbeat watchdog.
- Synchronises `hb_pulse`, counts beats, and flags a stall when beats stop arriving.
- Blinks an N-flash error code on request from the linked-list control logic.
- Sits between the heartbeat generator and the top-level LED pin.

---
 rtl/hb_monitor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hb_monitor.sv
// rtl/hb_monitor.sv - heartbeat watchdog, beat counter and status LED with error-code flasher
// Optional macro HB_MON_STICKY_EN adds stall_clr input and sticky stall_seen output.
module hb_monitor #(
  parameter int TIMEOUT_CYC = 256,
  parameter int BEAT_W      = 16,
  parameter int CODE_W      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hb_pulse,
  input  logic              err_valid,
  input  logic [CODE_W-1:0] err_code,
  output logic              err_ready,
  output logic              led,
  output logic              hb_stall,
  output logic [BEAT_W-1:0] beat_cnt
`ifdef HB_MON_STICKY_EN
  ,
  input  logic              stall_clr,
  output logic              stall_seen
`endif
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {WAIT_FIRST, RUN, CODE, STALL} state_e;

  state_e            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [BEAT_W-1:0] beat_q;
  logic [CODE_W-1:0] code_q, flash_q;
  logic              gap_q;
  logic              led_q, stall_q;
  logic              rise, timeout, accept;

  assign rise      = s2_q & ~s3_q;
  assign timeout   = (wd_q == WD_MAX) & ~rise;
  assign err_ready = (state_q == RUN) & ~timeout;
  assign accept    = err_valid & err_ready & (err_code != '0);
  assign wd_d      = rise ? '0 : ((wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_FIRST;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      wd_q    <= '0;
      beat_q  <= '0;
      code_q  <= '0;
      flash_q <= '0;
      gap_q   <= 1'b0;
      led_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      s1_q <= hb_pulse;
      s2_q <= s1_q;
      s3_q <= s2_q;
      wd_q <= wd_d;
      if (rise) beat_q <= beat_q + BEAT_W'(1);
      case (state_q)
        WAIT_FIRST: begin
          if (rise) begin
            state_q <= RUN;
            led_q   <= s2_q;
          end else if (timeout) begin
            state_q <= STALL;
            led_q   <= 1'b1;
            stall_q <= 1'b1;
          end
        end
        RUN: begin
          if (timeout) begin
            state_q <= STALL;
            led_q   <= 1'b1;
            stall_q <= 1'b1;
          end else if (accept) begin
            state_q <= CODE;
            code_q  <= err_code;
            flash_q <= '0;
            gap_q   <= 1'b0;
            led_q   <= 1'b0;
          end else begin
            led_q <= s2_q;
          end
        end
        CODE: begin
          // Each beat toggles the LED; after the last flash, two dark beats separate the code
          if (timeout) begin
            state_q <= STALL;
            led_q   <= 1'b1;
            stall_q <= 1'b1;
          end else if (rise) begin
            if (led_q) begin
              led_q <= 1'b0;
            end else if (flash_q != code_q) begin
              led_q   <= 1'b1;
              flash_q <= flash_q + CODE_W'(1);
            end else if (gap_q) begin
              state_q <= RUN;
              led_q   <= s2_q;
            end else begin
              gap_q <= 1'b1;
            end
          end
        end
        STALL: begin
          if (rise) begin
            state_q <= RUN;
            stall_q <= 1'b0;
            led_q   <= s2_q;
          end
        end
        default: state_q <= WAIT_FIRST;
      endcase
    end
  end

  assign led      = led_q;
  assign hb_stall = stall_q;
  assign beat_cnt = beat_q;

`ifdef HB_MON_STICKY_EN
  logic seen_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         seen_q <= 1'b0;
    else if (timeout && state_q != STALL) seen_q <= 1'b1;
    else if (stall_clr)                   seen_q <= 1'b0;
  end

  assign stall_seen = seen_q;
`endif

endmodule
